// File: rtl/sdram_frame_reader_if.sv
// rtl/sdram_frame_reader_if.sv - SDRAM read-request port and pixel stream of the frame reader.
interface sdram_frame_reader_if #(
  parameter int PixelWidth = 16,
  parameter int DataWidth  = 16,
  parameter int AddrWidth  = 24
);
  logic                  sdram_busy;
  logic                  sdram_valid_rd;
  logic [DataWidth-1:0]  sdram_data;
  logic                  sdram_enable;
  logic                  sdram_rw;
  logic [AddrWidth-1:0]  sdram_addr;
  logic [PixelWidth-1:0] pixel;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic                  line_end;

  modport master (
    input  sdram_busy, sdram_valid_rd, sdram_data, pixel_ready,
    output sdram_enable, sdram_rw, sdram_addr, pixel, pixel_valid, line_end
  );

  modport slave (
    output sdram_busy, sdram_valid_rd, sdram_data, pixel_ready,
    input  sdram_enable, sdram_rw, sdram_addr, pixel, pixel_valid, line_end
  );
endinterface

// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - fetches one frame from SDRAM in bursts and streams it pixel by pixel.
module sdram_frame_reader #(
  parameter int FrameWidth        = 640,
  parameter int FrameHeight       = 480,
  parameter int PixelBitWidth     = 16,
  parameter int WordLengthSDRAM   = 16,
  parameter int AddressWidthSDRAM = 24,
  parameter int BurstLengthSDRAM  = 8,
  parameter logic [AddressWidthSDRAM-1:0] BaseAddress = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  sdram_frame_reader_if.master bus
);
  localparam int Pixels = FrameWidth * FrameHeight;
  localparam int PixW   = $clog2(Pixels + 1);
  localparam int ColW   = $clog2(FrameWidth);
  localparam int IdxW   = $clog2(BurstLengthSDRAM);
  localparam logic [PixW-1:0] PixTotal = PixW'(Pixels);
  localparam logic [ColW-1:0] LastCol  = ColW'(FrameWidth - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BurstLengthSDRAM - 1);
  localparam logic [AddressWidthSDRAM-1:0] BurstStep = AddressWidthSDRAM'(BurstLengthSDRAM);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

  state_t                       state;
  logic [WordLengthSDRAM-1:0]   burst_buf [BurstLengthSDRAM];
  logic [IdxW-1:0]              wr_idx;
  logic [IdxW-1:0]              rd_idx;
  logic [AddressWidthSDRAM-1:0] addr;
  logic [PixW-1:0]              pix_cnt;
  logic [ColW-1:0]              col;
  logic [PixW-1:0]              pix_next;
  logic [ColW-1:0]              col_next;

  assign pix_next = pix_cnt + 1'b1;
  assign col_next = (col == LastCol) ? '0 : col + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      for (int i = 0; i < BurstLengthSDRAM; i++) burst_buf[i] <= '0;
      wr_idx           <= '0;
      rd_idx           <= '0;
      addr             <= '0;
      pix_cnt          <= '0;
      col              <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      bus.sdram_enable <= 1'b0;
      bus.sdram_rw     <= 1'b0;
      bus.sdram_addr   <= '0;
      bus.pixel        <= '0;
      bus.pixel_valid  <= 1'b0;
      bus.line_end     <= 1'b0;
    end else begin
      bus.sdram_enable <= 1'b0;
      bus.sdram_rw     <= 1'b0;
      frame_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr    <= BaseAddress;
            pix_cnt <= '0;
            col     <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!bus.sdram_busy) begin
            bus.sdram_enable <= 1'b1;
            bus.sdram_rw     <= 1'b1;
            bus.sdram_addr   <= addr;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (bus.sdram_valid_rd) begin
            burst_buf[wr_idx] <= bus.sdram_data;
            if (wr_idx == LastIdx) begin
              // Word 0 may be the word arriving right now when the burst is one word long.
              wr_idx          <= '0;
              rd_idx          <= '0;
              bus.pixel       <= (wr_idx == '0) ? bus.sdram_data : burst_buf[0];
              bus.pixel_valid <= 1'b1;
              bus.line_end    <= (col == LastCol);
              state           <= DRAIN;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.pixel_ready) begin
            pix_cnt <= pix_next;
            col     <= col_next;
            if (rd_idx == LastIdx) begin
              rd_idx          <= '0;
              bus.pixel       <= '0;
              bus.pixel_valid <= 1'b0;
              bus.line_end    <= 1'b0;
              if (pix_next == PixTotal) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                addr  <= addr + BurstStep;
                state <= REQ;
              end
            end else begin
              rd_idx       <= rd_idx + 1'b1;
              bus.pixel    <= burst_buf[rd_idx + 1'b1];
              bus.line_end <= (col_next == LastCol);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb/tb_sdram_frame_reader.sv - scoreboard bench for sdram_frame_reader on a 16x2 frame.
module tb_sdram_frame_reader;
  localparam int FW   = 16;
  localparam int FH   = 2;
  localparam int BL   = 8;
  localparam int NPIX = FW * FH;

  typedef struct packed {
    logic [15:0] pix;
    logic        le;
    logic        last;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, busy_b, fd_a, fd_b;
  logic sb_busy = 1'b0, sb_vrd = 1'b0, rdy = 1'b1;
  logic [15:0] sb_data = '0;

  sdram_frame_reader_if #(.PixelWidth(16), .DataWidth(16), .AddrWidth(24)) ia ();
  sdram_frame_reader_if #(.PixelWidth(16), .DataWidth(16), .AddrWidth(24)) ib ();

  assign ia.sdram_busy = sb_busy;  assign ib.sdram_busy = sb_busy;
  assign ia.sdram_valid_rd = sb_vrd;  assign ib.sdram_valid_rd = sb_vrd;
  assign ia.sdram_data = sb_data;  assign ib.sdram_data = sb_data;
  assign ia.pixel_ready = rdy;  assign ib.pixel_ready = rdy;

  sdram_frame_reader #(.FrameWidth(FW), .FrameHeight(FH), .BurstLengthSDRAM(BL),
                       .BaseAddress(24'h000000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .frame_done(fd_a), .bus(ia));
  sdram_frame_reader #(.FrameWidth(FW), .FrameHeight(FH), .BurstLengthSDRAM(BL),
                       .BaseAddress(24'hFFFFF8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .frame_done(fd_b), .bus(ib));

  pix_t        exp_pix [$];
  logic [23:0] exp_req [$];
  int tests = 0, fails = 0;
  int cyc = 0, chk_en_at = -10, done_at = -10, acc_cnt = 0;
  int drain_req = 0, drain_ack = 0;
  int busy_mode = 2, ready_mode = 0, rphase = 0, rsp_left = 0;
  logic [23:0] rsp_addr = '0;
  logic        prev_held = 1'b0, prev_le = 1'b0;
  logic [15:0] prev_pix = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic en, rw, pv, le, fd, bz;
    logic [23:0] ad;
    logic [15:0] px;
    logic [17:0] ex;
    pix_t e;
    cyc++;
    en = ia.sdram_enable | ib.sdram_enable;
    rw = ia.sdram_rw | ib.sdram_rw;
    ad = ia.sdram_enable ? ia.sdram_addr : ib.sdram_addr;
    pv = ia.pixel_valid | ib.pixel_valid;
    px = ia.pixel_valid ? ia.pixel : ib.pixel;
    le = ia.line_end | ib.line_end;
    fd = fd_a | fd_b;
    bz = busy_a | busy_b;
    if (!rst_n) begin
      check("reset_outputs_a", {ia.sdram_enable, ia.sdram_rw, ia.sdram_addr, ia.pixel,
                                ia.pixel_valid, ia.line_end, busy_a, fd_a}, 64'd0);
      check("reset_outputs_b", {ib.sdram_enable, ib.pixel_valid, busy_b, fd_b}, 64'd0);
      rsp_left = 0;
      prev_held = 1'b0;
      sb_vrd = 1'b0;
    end else begin
      if (en || rw) begin
        check("req_rw", rw, en);
        check("req_after_busy_low", sb_busy, 0);
        check("req_addr", ad, (exp_req.size() != 0) ? {40'd0, exp_req.pop_front()} : 64'hBAD0_0000);
      end
      if (en) begin
        rsp_left = BL;
        rsp_addr = ad;
      end
      if (cyc == chk_en_at)     check("en_after_busy_drop", en, 1);
      if (cyc == chk_en_at + 1) check("en_one_cycle", en, 0);
      if (prev_held) begin
        check("held_valid", pv, 1);
        check("held_pixel", {px, le}, {prev_pix, prev_le});
      end
      if (fd || cyc == done_at) check("frame_done", fd, (cyc == done_at));
      if (cyc == done_at + 1)   check("idle_after_done", bz, 0);
      if (drain_ack != drain_req) begin
        check("queues_drained", exp_req.size() + exp_pix.size(), 0);
        check("idle_at_end", bz, 0);
        drain_ack = drain_req;
      end
      case (busy_mode)
        1:       sb_busy = 1'b1;
        2:       sb_busy = 1'b0;
        default: sb_busy = ($urandom_range(0, 3) == 0);
      endcase
      case (ready_mode)
        0: rdy = 1'b1;
        1: begin
          rdy = (rphase != 1 && rphase != 2);
          rphase = (rphase + 1) % 3;
        end
        default: rdy = $urandom_range(0, 1) == 1;
      endcase
      if (pv && rdy) begin
        if (exp_pix.size() != 0) begin
          e = exp_pix.pop_front();
          ex = {1'b0, e.pix, e.le};
          if (e.last) done_at = cyc + 1;
        end else begin
          ex = 18'h20000;
        end
        check("pixel", {px, le}, ex);
        acc_cnt++;
      end
      prev_held = pv && !rdy;
      prev_pix = px;
      prev_le = le;
      // Outside a burst the reader is never in WAIT, so stray valid_rd words must be ignored.
      if (rsp_left > 0) begin
        if ($urandom_range(0, 2) != 0) begin
          sb_vrd = 1'b1;
          sb_data = rsp_addr[15:0];
          rsp_addr = rsp_addr + 24'd1;
          rsp_left--;
        end else begin
          sb_vrd = 1'b0;
          sb_data = 16'(($urandom));
        end
      end else begin
        sb_vrd = ($urandom_range(0, 3) == 0);
        sb_data = 16'hDEAD;
      end
    end
  end

  task automatic push_frame(input logic [23:0] base);
    pix_t e;
    logic [23:0] a;
    for (int b = 0; b < NPIX / BL; b++) exp_req.push_back(base + 24'(b * BL));
    for (int k = 0; k < NPIX; k++) begin
      a = base + 24'(k);
      e.pix = a[15:0];
      e.le = (k % FW == FW - 1);
      e.last = (k == NPIX - 1);
      exp_pix.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit which);
    @(posedge clk); #2;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_req.size() + exp_pix.size()) != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2 drain_req++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    push_frame(24'h0); pulse_start(0); wait_drain();

    #2 ready_mode = 1; busy_mode = 0;
    push_frame(24'h0); pulse_start(0); wait_drain();

    #2 ready_mode = 2;
    push_frame(24'h0); pulse_start(0); wait_drain();

    #2 busy_mode = 1; ready_mode = 0;
    push_frame(24'h0); pulse_start(0);
    repeat (10) @(posedge clk);
    #2 busy_mode = 2; chk_en_at = cyc + 2;
    wait_drain();

    #2 busy_mode = 0; ready_mode = 2;
    a0 = acc_cnt;
    push_frame(24'h0); pulse_start(0);
    repeat (5) @(posedge clk);
    pulse_start(0);
    for (int i = 0; i < 2000 && acc_cnt < a0 + 12; i++) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_req.delete();
    exp_pix.delete();
    repeat (2) @(posedge clk);
    #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    push_frame(24'h0); pulse_start(0); wait_drain();

    push_frame(24'hFFFFF8); pulse_start(1); wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
